// File: rtl/block_mem_loader.sv
// block_mem_loader: writes one 8-line raster strip into block memory in block-major order; ports clock/reset, in_valid/in_ready/in_data, wr_en/wr_addr/wr_data, strip_done/strip_count, strip_release
module block_mem_loader #(
    parameter int BLOCKS = 32,
    parameter int AW     = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          strip_done,
    input  logic          strip_release,
    output logic [31:0]   strip_count
);
    localparam int XW = AW - 3;
    typedef enum logic {LOAD, FULL} state_t;
    state_t state, state_next;
    logic [XW-1:0] x;
    logic [2:0] y;
    logic xfer, x_last, strip_last, last_q;
    always_comb begin
        in_ready   = state == LOAD;
        xfer       = in_valid && in_ready;
        x_last     = x == XW'(BLOCKS * 8 - 1);
        strip_last = xfer && x_last && y == 3'd7;
        state_next = strip_last ? FULL : (state == FULL && strip_release) ? LOAD : state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LOAD;
            x           <= '0;
            y           <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            last_q      <= 1'b0;
            strip_done  <= 1'b0;
            strip_count <= '0;
        end else begin
            state       <= state_next;
            x           <= xfer ? (x_last ? '0 : x + XW'(1)) : x;
            y           <= (xfer && x_last) ? y + 3'd1 : y;
            wr_en       <= xfer;
            wr_addr     <= xfer ? ({x & ~XW'(7), 3'b000} | AW'({y, x[2:0]})) : wr_addr;
            wr_data     <= xfer ? in_data : wr_data;
            last_q      <= strip_last;
            strip_done  <= last_q;
            strip_count <= last_q ? strip_count + 32'd1 : strip_count;
        end
    end
endmodule

// File: tb/tb_block_mem_loader.sv
// tb_block_mem_loader: directed self-checking bench for block_mem_loader
module tb_block_mem_loader;
    logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, strip_release = 1'b0;
    logic in_ready, wr_en, strip_done;
    logic [31:0] in_data = '0, wr_data, strip_count;
    logic [10:0] wr_addr;
    int checks = 0, errors = 0, done_cnt = 0;
    int addr_q[$], data_q[$];
    always #5 clock = ~clock;
    block_mem_loader #(.BLOCKS(32), .AW(11)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .strip_done(strip_done), .strip_release(strip_release), .strip_count(strip_count)
    );
    always @(negedge clock) begin
        if (wr_en) begin
            addr_q.push_back(int'(wr_addr));
            data_q.push_back(int'(wr_data));
        end
        if (strip_done) done_cnt++;
    end
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    function automatic int exp_addr(input int k);
        return ((k % 256) / 8) * 64 + (k / 256) * 8 + k % 8;
    endfunction
    task automatic push(input int k, input bit rnd);
        bit acc;
        in_data = k;
        for (int t = 0; t < 100; t++) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = in_valid && in_ready;
            step();
            if (acc) return;
        end
        check("accept stall", 32'd1, 32'd0);
    endtask
    task automatic send(input int first, input int last, input bit rnd);
        for (int k = first; k <= last; k++) push(k, rnd);
        in_valid = 1'b0;
    endtask
    task automatic pulse_release();
        strip_release = 1'b1;
        step();
        strip_release = 1'b0;
    endtask
    task automatic clear_q();
        addr_q.delete();
        data_q.delete();
    endtask
    task automatic check_seq(input string tag);
        int bad = 0;
        check({tag, " len"}, addr_q.size(), 2048);
        for (int i = 0; i < 2048 && i < addr_q.size(); i++)
            if (addr_q[i] != exp_addr(i) || data_q[i] != i) bad++;
        check({tag, " order"}, bad, 0);
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " wr_en"}, wr_en, 0);
        check({tag, " wr_addr"}, wr_addr, 0);
        check({tag, " wr_data"}, wr_data, 0);
        check({tag, " strip_done"}, strip_done, 0);
        check({tag, " strip_count"}, strip_count, 0);
    endtask
    initial begin
        int bad, d;
        step();
        step();
        reset = 1'b0;
        check_reset_outputs("reset");
        clear_q();
        send(0, 2047, 1'b0);
        check("last in_ready", in_ready, 0);
        check("last wr_en", wr_en, 1);
        check("last wr_addr", wr_addr, 2047);
        check("last wr_data", wr_data, 2047);
        check("done early", strip_done, 0);
        step();
        check("done pulse", strip_done, 1);
        check("count 1", strip_count, 1);
        check("wr_en after last", wr_en, 0);
        check_seq("strip1");
        check("pix0 addr", addr_q[0], 0);
        check("pix8 addr", addr_q[8], 64);
        check("pix256 addr", addr_q[256], 8);
        check("pix2047 addr", addr_q[2047], 2047);
        bad = 0;
        in_valid = 1'b1;
        in_data = 32'hdead;
        for (int i = 0; i < 20; i++) begin
            step();
            if (in_ready || wr_en) bad++;
        end
        in_valid = 1'b0;
        check("hold activity", bad, 0);
        check("hold done count", done_cnt, 1);
        clear_q();
        pulse_release();
        check("release in_ready", in_ready, 1);
        send(0, 2047, 1'b1);
        step();
        check("strip2 first addr", addr_q[0], 0);
        check_seq("random");
        check("count 2", strip_count, 2);
        pulse_release();
        send(0, 999, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        strip_release = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        strip_release = 1'b0;
        check_reset_outputs("midreset");
        d = done_cnt;
        repeat (5) step();
        check("midreset no done", done_cnt, d);
        clear_q();
        send(0, 2047, 1'b0);
        step();
        check_seq("after reset");
        check("after reset count", strip_count, 1);
        pulse_release();
        d = done_cnt;
        send(0, 2046, 1'b0);
        strip_release = 1'b1;
        push(2047, 1'b0);
        in_valid = 1'b0;
        strip_release = 1'b0;
        check("release on last ignored", in_ready, 0);
        step();
        check("edge done", strip_done, 1);
        check("edge still full", in_ready, 0);
        strip_release = 1'b1;
        step();
        strip_release = 1'b0;
        check("release in done cycle", in_ready, 1);
        check("done single", strip_done, 0);
        check("edge done count", done_cnt, d + 1);
        check("edge strip_count", strip_count, 2);
        force dut.strip_count = 32'hFFFFFFFF;
        step();
        release dut.strip_count;
        check("preload", strip_count, 32'hFFFFFFFF);
        send(0, 2047, 1'b0);
        step();
        check("count wrap", strip_count, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
